div_arbiter: RTL and testbench
==============================

# div_arbiter

Shares one sequential 32/32 divider among N motion channels (one `dda` velocity planner per axis). Each channel raises a one-cycle divide request with its operands. The arbiter queues requests per channel, grants the divider round-robin, and routes the quotient back with a per-channel done pulse. It sits between the axis planners and the single divider instance in the motion core.

## Interface
Parameters:
- `N`, 4: number of requesting channels, 2..8.
- `CH_W`, clog2(N): channel index width.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_start`  in  N  per-channel one-cycle divide request.
- `req_divident`  in  N*32  per-channel dividend; channel k is bits [32k+31:32k]; sampled only when `req_start[k]`=1.
- `req_divisor`  in  N*32  per-channel divisor; same packing and sampling as `req_divident`.
- `req_done`  out  N  one-cycle result strobe to the owning channel.
- `quotient`  out  64  last delivered result, shared by all channels; valid when any `req_done` bit is high, held afterwards.
- `div_divident`  out  32  operand to the divider.
- `div_divisor`  out  32  operand to the divider.
- `div_start`  out  1  one-cycle divider start.
- `div_quotient`  in  64  divider result.
- `div_done`  in  1  divider completion strobe.
- `busy`  out  1  high in any state other than IDLE.

## Operation
Per-channel request buffer:
- `pend[k]`, `opa[k]`, `opb[k]`.
- `req_start[k]` writes `opa`/`opb` and sets `pend[k]`, even if the channel is already pending. A second request before service overwrites the operands; only one result is returned.

States: IDLE, ISSUE, WAIT, DELIVER.
- **IDLE:** if any `pend` bit is set, pick the first pending channel starting at `last+1` mod N, wrapping.
  - Latch it as `owner`, set `last`=`owner`, clear `pend[owner]`.
  - Copy its operands to `div_divident`/`div_divisor`.
  - If divisor ≠ 0, go to ISSUE. If divisor = 0, load `quotient`=0 and go to DELIVER; the divider is not started.
- **ISSUE:** `div_start`=1 for exactly this one cycle. Go to WAIT.
- **WAIT:** hold the operand outputs. On `div_done`=1:
  - If `stale`=0, register `div_quotient` into `quotient`.
  - Go to DELIVER.
- **DELIVER:**
  - `req_done[owner]`=1 for one cycle unless `stale`.
  - Clear `stale`; go to IDLE.
- **Stale rule:** `req_start[owner]` during ISSUE or WAIT sets `stale` and `pend[owner]`.
  - The in-flight result is then discarded: no `req_done`, `quotient` unchanged.
  - The new request is serviced in normal round-robin order.
- **`req_start[owner]` in DELIVER:** only sets `pend`. The current delivery stands.
- **`div_done` outside WAIT:** ignored.
- **Reset:**
  - Clears `pend`, `stale`, and `state`=IDLE.
  - Sets `last`=N-1, so channel 0 has first priority.
  - Outputs reset to: `req_done`=0, `quotient`=0, `div_start`=0, `div_divident`=0, `div_divisor`=0, `busy`=0.
  - The divider shares `reset`, so a mid-operation reset aborts both blocks.

## Timing
- All outputs are registered.
- `req_start[k]` at cycle t → `pend[k]` set at t+1. With the arbiter in IDLE, `div_start`=1 in cycle t+2.
- `div_done` in cycle d → `req_done`/`quotient` valid in cycle d+1. One idle cycle follows before the next ISSUE.
- Minimum back-to-back spacing between divider starts is divider latency + 3 cycles.
- Divisor = 0: `req_done` arrives in cycle t+3.
- Fairness: a continuously pending channel waits at most N-1 services.
- A pending request is never lost; only operand overwrite (a later request) replaces it.

## Structure
- Package `motion_pkg` holds:
  - state encodings `ARB_IDLE`/`ARB_ISSUE`/`ARB_WAIT`/`ARB_DELIVER`;
  - `DIV_W`=32 and `QUO_W`=64;
  - `DIV_ZERO_RESULT`=0.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `pend[N-1:0]` and `last[CH_W-1:0]`.
  - Outputs: `valid` and `grant_idx`.
- The arbiter instantiates `rr_pick` once.

## Test plan
- **Single request:** ch1 requests 1000/10, divider latency 34 → `div_start` at t+2 with operands 1000/10; `req_done[1]` for one cycle with `quotient`=100; no other `req_done` bit pulses.
- **Simultaneous requests:** all four channels request in the same cycle after reset → service order 0,1,2,3, each receiving its own quotient; repeating the burst gives the same order. A burst after ch2 was served last gives order 3,0,1,2.
- **Divide by zero:** ch3 requests 500/0 → `div_start` never asserts; `req_done[3]` at t+3 with `quotient`=0.
- **Re-request in flight:** ch0 re-requests 300/3 while its 200/2 is in WAIT → the first result is dropped and `quotient` keeps its old value; then 300/3 is issued and `req_done[0]` returns 100 exactly once.
- **Operand overwrite:** ch2 requests twice while ch1 is being served → only the second operands reach the divider; one `req_done[2]`.
- **Reset mid-operation:** reset asserted during WAIT with ch1 pending → all outputs return to reset values next cycle and ch1 is never served; a stray `div_done` after reset produces no `req_done`.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared definitions for the motion core: datapath widths, arbiter state
// encodings and the result returned for a zero divisor.
package motion_pkg;

    localparam int DIV_W = 32;
    localparam int QUO_W = 64;

    localparam logic [QUO_W-1:0] DIV_ZERO_RESULT = '0;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_ISSUE   = 2'd1,
        ARB_WAIT    = 2'd2,
        ARB_DELIVER = 2'd3
    } arb_state_t;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first pending channel found
// when scanning upward from last+1, wrapping modulo N.
module rr_pick #(
    parameter int N    = 4,
    parameter int CH_W = $clog2(N)
) (
    input  logic [N-1:0]    pend,
    input  logic [CH_W-1:0] last,
    output logic            valid,
    output logic [CH_W-1:0] grant_idx
);

    // cand_idx[i] is the channel visited at scan position i (offset i+1 from last)
    logic [CH_W-1:0] cand_idx [N];
    logic [N-1:0]    cand_hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign cand_idx[gi] = CH_W'((int'(last) + gi + 1) % N);
            assign cand_hit[gi] = pend[cand_idx[gi]];
        end
    endgenerate

    // Lowest scan position with a pending channel wins
    always_comb begin
        valid     = |cand_hit;
        grant_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                grant_idx = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider among N axis planners. Requests are buffered
// per channel, granted round-robin, and the quotient is returned with a
// one-cycle done strobe to the owning channel. All outputs are registered.
import motion_pkg::*;

module div_arbiter #(
    parameter int N    = 4,
    parameter int CH_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       req_start,
    input  logic [N*DIV_W-1:0] req_divident,
    input  logic [N*DIV_W-1:0] req_divisor,
    output logic [N-1:0]       req_done,
    output logic [QUO_W-1:0]   quotient,
    output logic [DIV_W-1:0]   div_divident,
    output logic [DIV_W-1:0]   div_divisor,
    output logic               div_start,
    input  logic [QUO_W-1:0]   div_quotient,
    input  logic               div_done,
    output logic               busy
);

    arb_state_t state_reg, state_next;

    logic [N-1:0]     pend_reg, pend_next;
    logic [DIV_W-1:0] opa_reg [N];
    logic [DIV_W-1:0] opb_reg [N];
    logic [CH_W-1:0]  last_reg, owner_reg;
    logic             stale_reg;
    logic             zero_reg;   // current service is a divide-by-zero shortcut

    logic             pick_valid;
    logic [CH_W-1:0]  pick_idx;
    logic             grant_en;
    logic             pick_zero;
    logic             owner_hit;
    logic             in_flight;

    logic [N-1:0]     req_done_reg, req_done_next;
    logic [QUO_W-1:0] quotient_reg, quotient_next;
    logic [DIV_W-1:0] div_divident_reg, div_divident_next;
    logic [DIV_W-1:0] div_divisor_reg, div_divisor_next;
    logic             div_start_reg, div_start_next;
    logic             busy_reg, busy_next;

    rr_pick #(
        .N    (N),
        .CH_W (CH_W)
    ) u_pick (
        .pend      (pend_reg),
        .last      (last_reg),
        .valid     (pick_valid),
        .grant_idx (pick_idx)
    );

    assign grant_en  = (state_reg == ARB_IDLE) && pick_valid;
    assign pick_zero = (opb_reg[pick_idx] == '0);
    assign owner_hit = req_start[owner_reg];
    assign in_flight = (state_reg == ARB_ISSUE) || (state_reg == ARB_WAIT);

    // A new request always (re)arms the channel, even when it is granted the
    // same cycle, so a request is never lost
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pend
            assign pend_next[gi] = req_start[gi] ? 1'b1 :
                                   (grant_en && (pick_idx == CH_W'(gi))) ? 1'b0 :
                                   pend_reg[gi];
        end
    endgenerate

    // Per-channel operand buffers; a later request overwrites earlier operands
    always_ff @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (req_start[k]) begin
                opa_reg[k] <= req_divident[k*DIV_W +: DIV_W];
                opb_reg[k] <= req_divisor[k*DIV_W +: DIV_W];
            end
        end
    end

    // Pending flags, owner bookkeeping and the stale marker
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_reg  <= '0;
            last_reg  <= CH_W'(N - 1);
            owner_reg <= '0;
            stale_reg <= 1'b0;
            zero_reg  <= 1'b0;
        end else begin
            pend_reg <= pend_next;
            if (grant_en) begin
                owner_reg <= pick_idx;
                last_reg  <= pick_idx;
                zero_reg  <= pick_zero;
            end
            if (state_reg == ARB_DELIVER) begin
                stale_reg <= 1'b0;
            end else if (in_flight && owner_hit) begin
                stale_reg <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_next = pick_zero ? ARB_DELIVER : ARB_ISSUE;
                end
            end
            ARB_ISSUE:   state_next = ARB_WAIT;
            ARB_WAIT: begin
                if (div_done) begin
                    state_next = ARB_DELIVER;
                end
            end
            ARB_DELIVER: state_next = ARB_IDLE;
            default:     state_next = ARB_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered outputs. A re-request
    // landing in the same cycle as div_done also discards the result.
    always_comb begin
        req_done_next     = '0;
        quotient_next     = quotient_reg;
        div_divident_next = div_divident_reg;
        div_divisor_next  = div_divisor_reg;
        div_start_next    = (state_next == ARB_ISSUE);
        busy_next         = (state_next != ARB_IDLE);
        case (state_reg)
            ARB_IDLE: begin
                if (pick_valid) begin
                    div_divident_next = opa_reg[pick_idx];
                    div_divisor_next  = opb_reg[pick_idx];
                    if (pick_zero) begin
                        quotient_next = DIV_ZERO_RESULT;
                    end
                end
            end
            ARB_WAIT: begin
                if (div_done && !(stale_reg || owner_hit)) begin
                    quotient_next            = div_quotient;
                    req_done_next[owner_reg] = 1'b1;
                end
            end
            ARB_DELIVER: begin
                if (zero_reg) begin
                    req_done_next[owner_reg] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            req_done_reg     <= '0;
            quotient_reg     <= '0;
            div_divident_reg <= '0;
            div_divisor_reg  <= '0;
            div_start_reg    <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            req_done_reg     <= req_done_next;
            quotient_reg     <= quotient_next;
            div_divident_reg <= div_divident_next;
            div_divisor_reg  <= div_divisor_next;
            div_start_reg    <= div_start_next;
            busy_reg         <= busy_next;
        end
    end

    assign req_done     = req_done_reg;
    assign quotient     = quotient_reg;
    assign div_divident = div_divident_reg;
    assign div_divisor  = div_divisor_reg;
    assign div_start    = div_start_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural fixed-latency divider.
module tb_div_arbiter;

    localparam int N   = 4;
    localparam int LAT = 34;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_start = '0;
    logic [N*32-1:0] req_divident = '0;
    logic [N*32-1:0] req_divisor = '0;
    logic [N-1:0]  req_done;
    logic [63:0]   quotient;
    logic [31:0]   div_divident;
    logic [31:0]   div_divisor;
    logic          div_start;
    logic [63:0]   div_quotient = '0;
    logic          div_done;
    logic          busy;

    logic          model_done = 1'b0;
    logic          stray_done = 1'b0;
    int            cnt = 0;
    logic [31:0]   ma = '0, mb = '0;

    int            total = 0;
    int            bad = 0;
    int            start_cnt = 0;
    logic [31:0]   last_a = '0, last_b = '0;

    always #5 clk = ~clk;

    assign div_done = model_done | stray_done;

    div_arbiter #(.N(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_start    (req_start),
        .req_divident (req_divident),
        .req_divisor  (req_divisor),
        .req_done     (req_done),
        .quotient     (quotient),
        .div_divident (div_divident),
        .div_divisor  (div_divisor),
        .div_start    (div_start),
        .div_quotient (div_quotient),
        .div_done     (div_done),
        .busy         (busy)
    );

    // Behavioural divider: done strobe LAT cycles after start
    always @(posedge clk) begin
        model_done <= 1'b0;
        if (reset) begin
            cnt <= 0;
        end else if (div_start) begin
            cnt <= LAT;
            ma  <= div_divident;
            mb  <= div_divisor;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                model_done   <= 1'b1;
                div_quotient <= {32'd0, (mb != 0) ? ma / mb : 32'hFFFF_FFFF};
            end
        end
    end

    // Record every divider start and its operands
    always @(negedge clk) begin
        if (div_start) begin
            start_cnt = start_cnt + 1;
            last_a    = div_divident;
            last_b    = div_divisor;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic [31:0] a, input logic [31:0] b);
        req_start[ch] = 1'b1;
        req_divident[ch*32 +: 32] = a;
        req_divisor[ch*32 +: 32]  = b;
    endtask

    task automatic do_reset();
        req_start = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Wait (bounded) for the next delivery and check owner, value and pulse width
    task automatic wait_done(input int ch, input logic [63:0] q, input string tag);
        logic [N-1:0] exp_mask;
        exp_mask = '0;
        exp_mask[ch] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (req_done != '0) break;
            tick();
        end
        $display("txn %s: req_done=%b quotient=%0d", tag, req_done, quotient);
        chk({tag, "_done"}, 64'(req_done), 64'(exp_mask));
        chk({tag, "_q"}, quotient, q);
        tick();
        chk({tag, "_pulse"}, 64'(req_done), 64'd0);
    endtask

    // Watch a quiet window; returns 1 if any delivery, start or busy was seen
    task automatic quiet(input int cycles, input logic chk_start, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (req_done != '0) seen = 1'b1;
            if (chk_start && (div_start || busy)) seen = 1'b1;
            tick();
        end
    endtask

    initial begin
        int   s0;
        logic seen;
        logic q_held;

        // ---- reset state ----
        do_reset();
        chk("rst_req_done", 64'(req_done), 64'd0);
        chk("rst_quotient", quotient, 64'd0);
        chk("rst_div_start", 64'(div_start), 64'd0);
        chk("rst_divident", 64'(div_divident), 64'd0);
        chk("rst_divisor", 64'(div_divisor), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // ---- single request ch1 1000/10 ----
        set_req(1, 32'd1000, 32'd10);
        tick();
        req_start = '0;
        chk("single_t1_start", 64'(div_start), 64'd0);
        tick();
        chk("single_start", 64'(div_start), 64'd1);
        chk("single_a", 64'(div_divident), 64'd1000);
        chk("single_b", 64'(div_divisor), 64'd10);
        chk("single_busy", 64'(busy), 64'd1);
        tick();
        chk("single_start_pulse", 64'(div_start), 64'd0);
        wait_done(1, 64'd100, "single");

        // ---- simultaneous burst after reset: order 0,1,2,3 twice ----
        do_reset();
        for (int r = 0; r < 2; r++) begin
            set_req(0, 32'd100, 32'd4);
            set_req(1, 32'd90, 32'd3);
            set_req(2, 32'd77, 32'd7);
            set_req(3, 32'd64, 32'd8);
            tick();
            req_start = '0;
            wait_done(0, 64'd25, "burst_c0");
            wait_done(1, 64'd30, "burst_c1");
            wait_done(2, 64'd11, "burst_c2");
            wait_done(3, 64'd8, "burst_c3");
        end

        // ---- ch2 served last, then burst: order 3,0,1,2 ----
        set_req(2, 32'd50, 32'd5);
        tick();
        req_start = '0;
        wait_done(2, 64'd10, "solo_c2");
        set_req(0, 32'd100, 32'd4);
        set_req(1, 32'd90, 32'd3);
        set_req(2, 32'd77, 32'd7);
        set_req(3, 32'd64, 32'd8);
        tick();
        req_start = '0;
        wait_done(3, 64'd8, "rot_c3");
        wait_done(0, 64'd25, "rot_c0");
        wait_done(1, 64'd30, "rot_c1");
        wait_done(2, 64'd11, "rot_c2");

        // ---- divide by zero ch3 500/0: done at t+3, no divider start ----
        s0 = start_cnt;
        set_req(3, 32'd500, 32'd0);
        tick();
        req_start = '0;
        chk("dz_t1_done", 64'(req_done), 64'd0);
        tick();
        chk("dz_t2_done", 64'(req_done), 64'd0);
        tick();
        chk("dz_t3_done", 64'(req_done), 64'b1000);
        chk("dz_t3_q", quotient, 64'd0);
        $display("txn dz: req_done=%b quotient=%0d", req_done, quotient);
        tick();
        chk("dz_pulse", 64'(req_done), 64'd0);
        chk("dz_no_start", 64'(start_cnt), 64'(s0));

        // ---- re-request in flight: ch0 200/2 then 300/3 during WAIT ----
        set_req(0, 32'd200, 32'd2);
        tick();
        req_start = '0;
        tick();
        chk("rr_first_start", 64'(div_start), 64'd1);
        tick();
        tick();
        set_req(0, 32'd300, 32'd3);
        tick();
        req_start = '0;
        s0 = start_cnt;
        q_held = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (req_done != '0) break;
            if (quotient !== 64'd0) q_held = 1'b0;
            tick();
        end
        chk("rr_q_held", 64'(q_held), 64'd1);
        chk("rr_reissued", 64'(start_cnt), 64'(s0 + 1));
        chk("rr_a", 64'(last_a), 64'd300);
        chk("rr_b", 64'(last_b), 64'd3);
        wait_done(0, 64'd100, "rr");
        quiet(80, 1'b1, seen);
        chk("rr_once", 64'(seen), 64'd0);

        // ---- operand overwrite: ch2 twice while ch1 is served ----
        set_req(1, 32'd81, 32'd9);
        tick();
        req_start = '0;
        tick();
        tick();
        tick();
        set_req(2, 32'd40, 32'd4);
        tick();
        req_start = '0;
        tick();
        tick();
        set_req(2, 32'd60, 32'd3);
        tick();
        req_start = '0;
        wait_done(1, 64'd9, "ow_c1");
        s0 = start_cnt;
        wait_done(2, 64'd20, "ow_c2");
        chk("ow_one_start", 64'(start_cnt), 64'(s0 + 1));
        chk("ow_a", 64'(last_a), 64'd60);
        chk("ow_b", 64'(last_b), 64'd3);
        quiet(80, 1'b1, seen);
        chk("ow_once", 64'(seen), 64'd0);

        // ---- reset during WAIT with ch1 pending ----
        set_req(0, 32'd10, 32'd1);
        set_req(1, 32'd99, 32'd9);
        tick();
        req_start = '0;
        tick();
        chk("mr_start", 64'(div_start), 64'd1);
        chk("mr_a", 64'(div_divident), 64'd10);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_req_done", 64'(req_done), 64'd0);
        chk("mr_quotient", quotient, 64'd0);
        chk("mr_div_start", 64'(div_start), 64'd0);
        chk("mr_divident", 64'(div_divident), 64'd0);
        chk("mr_divisor", 64'(div_divisor), 64'd0);
        chk("mr_busy", 64'(busy), 64'd0);
        tick();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        quiet(80, 1'b1, seen);
        chk("mr_quiet", 64'(seen), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
